fmas_arb: RTL and testbench

//  Shares one single-precision fmas unit (2-stage pipe, no stall input) among NREQ requesters.

---
 rtl/fmas_arb.sv | 124 ++++++++++++
 tb/tb_fmas_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fmas_arb.sv
// fmas_arb: round-robin sharing of one 2-stage fmas unit with a credit-protected, id-tagged response FIFO
// Ports: clk, reset (async, active-low); per requester req_valid/req_ready/req_x/req_y/req_z;
//   fmas_req/fmas_x/fmas_y/fmas_z issue side and fmas_rslt/fmas_flag return side;
//   rsp_valid/rsp_ready/rsp_id/rsp_rslt/rsp_flag response channel; busy.
// Optional FMAS_ARB_FLAGACC_EN adds flag_acc (sticky per-requester flags) and flag_clr.
module fmas_arb #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*32-1:0]        req_x,
  input  logic [NREQ*32-1:0]        req_y,
  input  logic [NREQ*32-1:0]        req_z,
  output logic                      fmas_req,
  output logic [31:0]               fmas_x,
  output logic [31:0]               fmas_y,
  output logic [31:0]               fmas_z,
  input  logic [31:0]               fmas_rslt,
  input  logic [4:0]                fmas_flag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [31:0]               rsp_rslt,
  output logic [4:0]                rsp_flag,
`ifdef FMAS_ARB_FLAGACC_EN
  output logic                      busy,
  output logic [NREQ*5-1:0]         flag_acc,
  input  logic [NREQ-1:0]           flag_clr
`else
  output logic                      busy
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + LAT + 1);
  localparam int EW = IW + 37;
  logic [IW-1:0]          rr_q, rr_d, win;
  logic [IW:0]            cand;
  logic                   hit, grant, push, pop;
  logic [OW-1:0]          occ;
  logic [LAT-1:0]         v_q;
  logic [LAT-1:0][IW-1:0] id_q;
  logic [31:0]            x_q, y_q, z_q;
  logic [AW-1:0]          wr_q, rd_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [EW-1:0]          mem_q [DEPTH];
  // first valid requester at or after rr_q, wrapping
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IW+1)'(k);
      cand = cand >= (IW+1)'(NREQ) ? cand - (IW+1)'(NREQ) : cand;
      if (!hit && req_valid[cand[IW-1:0]]) begin
        hit = 1'b1;
        win = cand[IW-1:0];
      end
    end
  end
  // every op in the tag pipe or FIFO holds a credit, so the FIFO can never overflow
  always_comb begin
    occ = OW'(cnt_q);
    for (int l = 0; l < LAT; l++) occ = occ + OW'(v_q[l]);
  end
  assign grant     = reset && hit && (occ < OW'(DEPTH));
  assign req_ready = grant ? NREQ'(1) << win : '0;
  assign fmas_req  = grant;
  assign fmas_x    = grant ? req_x[32*win +: 32] : x_q;
  assign fmas_y    = grant ? req_y[32*win +: 32] : y_q;
  assign fmas_z    = grant ? req_z[32*win +: 32] : z_q;
  assign rr_d      = grant ? (win == IW'(NREQ - 1) ? '0 : win + 1'b1) : rr_q;
  assign push      = v_q[LAT-1];
  assign rsp_valid = cnt_q != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign busy      = (|v_q) | rsp_valid;
  assign {rsp_id, rsp_rslt, rsp_flag} = mem_q[rd_q];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q  <= '0;
      v_q   <= '0;
      id_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      v_q   <= LAT'({v_q, grant});
      id_q  <= (LAT*IW)'({id_q, win});
      x_q   <= fmas_x;
      y_q   <= fmas_y;
      z_q   <= fmas_z;
      wr_q  <= push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_q  <= pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {id_q[LAT-1], fmas_rslt, fmas_flag};
  end
`ifdef FMAS_ARB_FLAGACC_EN
  logic [NREQ-1:0][4:0] acc_q, acc_d;
  // a clear in the same cycle as a pop leaves only the popped flags
  always_comb begin
    acc_d = '0;
    for (int i = 0; i < NREQ; i++)
      acc_d[i] = (flag_clr[i] ? 5'h0 : acc_q[i]) | (pop && rsp_id == IW'(i) ? rsp_flag : 5'h0);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign flag_acc = acc_q;
`endif
endmodule

// File: tb/tb_fmas_arb.sv
// tb_fmas_arb: randomized scoreboard bench for fmas_arb with an fmas stand-in
module tb_fmas_arb;
  localparam int N = 4, D = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*32-1:0] req_x = '0, req_y = '0, req_z = '0;
  logic fmas_req;
  logic [31:0] fmas_x, fmas_y, fmas_z, fmas_rslt;
  logic [4:0] fmas_flag;
  logic rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0] rsp_id;
  logic [31:0] rsp_rslt;
  logic [4:0] rsp_flag;
`ifdef FMAS_ARB_FLAGACC_EN
  logic [N*5-1:0] flag_acc;
  logic [N-1:0] flag_clr = '0, clr_next = '0;
  logic [4:0] macc [N];
`endif
  typedef struct { int id; logic [31:0] r; logic [4:0] f; int t; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, pushes = 0, pops = 0, rr = 0, rdy_pct = 100;
  bit gnow = 0, lvalid = 0;
  bit pend [N];
  logic [31:0] ox [N], oy [N], oz [N];
  logic [36:0] p1 = '0, p2 = '0;
  logic [95:0] last = '0;

  fmas_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .fmas_req(fmas_req),
    .fmas_x(fmas_x), .fmas_y(fmas_y), .fmas_z(fmas_z), .fmas_rslt(fmas_rslt),
    .fmas_flag(fmas_flag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_rslt(rsp_rslt), .rsp_flag(rsp_flag),
`ifdef FMAS_ARB_FLAGACC_EN
    .busy(busy), .flag_acc(flag_acc), .flag_clr(flag_clr)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fmas stand-in: known IEEE cases from the datasheet, otherwise a cheap deterministic mix
  function automatic logic [36:0] fm(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    if (x == 32'h3f800000 && y == 32'h40000000 && z == 32'h40400000) return {32'h40a00000, 5'h00};
    if (x == 32'h7f800001 && y == 32'h3f800000 && z == 32'h0) return {32'h7fc00001, 5'h10};
    if (x == 32'h7f7fffff && y == 32'h40000000 && z == 32'h0) return {32'h7f800000, 5'h05};
    return {x * y + z, 5'(x ^ y ^ z)};
  endfunction

  always @(posedge clk) begin
    p1 <= fm(fmas_x, fmas_y, fmas_z);
    p2 <= p1;
  end
  assign {fmas_rslt, fmas_flag} = p2;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic offer(input int i, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    pend[i] = 1;
    ox[i] = x;
    oy[i] = y;
    oz[i] = z;
  endtask

  task automatic step(input int pct);
    int w;
    logic [36:0] r;
    @(negedge clk);
`ifdef FMAS_ARB_FLAGACC_EN
    flag_clr = clr_next;
`endif
    for (int i = 0; i < N; i++)
      if (!pend[i] && $urandom_range(99) < pct) offer(i, $urandom, $urandom, $urandom);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_x[32*i +: 32] = ox[i];
      req_y[32*i +: 32] = oy[i];
      req_z[32*i +: 32] = oz[i];
    end
    #1;
    w = -1;
    if (pushes - pops < D)
      for (int k = 0; k < N; k++) if (w < 0 && pend[(rr + k) % N]) w = (rr + k) % N;
    gnow = w >= 0;
    check("req_ready", req_ready, gnow ? (128'(1) << w) : 128'(0));
    check("fmas_req", fmas_req, gnow);
    if (gnow) begin
      r = fm(ox[w], oy[w], oz[w]);
      last = {ox[w], oy[w], oz[w]};
      lvalid = 1;
      q.push_back('{w, r[36:5], r[4:0], cyc});
      pushes++;
      pend[w] = 0;
      rr = (w + 1) % N;
    end
    if (lvalid) check("fmas_xyz", {fmas_x, fmas_y, fmas_z}, last);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    req_valid = '0;
    gnow = 0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_fmas_req", fmas_req, 0);
    q.delete();
    pushes = 0;
    pops = 0;
    rr = 0;
    lvalid = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
`ifdef FMAS_ARB_FLAGACC_EN
    for (int i = 0; i < N; i++) macc[i] = '0;
    clr_next = '0;
    flag_clr = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a response
  initial forever begin
    @(negedge clk);
    rsp_ready = $urandom_range(99) < rdy_pct;
    #2;
    if (reset) begin
      if (q.size() > 0 && q[0].t + 3 <= cyc) check("rsp_late", rsp_valid, 1);
      check("busy", busy, q.size() > int'(gnow));
`ifdef FMAS_ARB_FLAGACC_EN
      begin
        logic [N*5-1:0] e;
        for (int i = 0; i < N; i++) e[5*i +: 5] = macc[i];
        check("flag_acc", flag_acc, e);
        for (int i = 0; i < N; i++) if (flag_clr[i]) macc[i] = '0;
        if (rsp_valid && rsp_ready && q.size() > 0) macc[q[0].id] = macc[q[0].id] | q[0].f;
      end
`endif
      if (rsp_valid) begin
        if (q.size() == 0) check("rsp_stale", rsp_valid, 0);
        else begin
          check("rsp", {rsp_id, rsp_rslt, rsp_flag}, {2'(q[0].id), q[0].r, q[0].f});
          check("rsp_early", q[0].t + 3 <= cyc, 1);
          if (rsp_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      ox[i] = '0;
      oy[i] = '0;
      oz[i] = '0;
    end
    do_reset();
    offer(0, 32'h3f800000, 32'h40000000, 32'h40400000);
    repeat (6) step(0);
    offer(2, 32'h7f800001, 32'h3f800000, 32'h0);
    repeat (6) step(0);
    repeat (12) step(100);
    rdy_pct = 0;
    repeat (10) step(100);
    rdy_pct = 100;
    repeat (10) step(100);
    repeat (12) step(0);
    rdy_pct = 0;
    offer(0, $urandom, $urandom, $urandom);
    offer(1, $urandom, $urandom, $urandom);
    offer(2, $urandom, $urandom, $urandom);
    repeat (3) step(0);
    do_reset();
    rdy_pct = 100;
    repeat (8) step(0);
`ifdef FMAS_ARB_FLAGACC_EN
    offer(1, 32'h7f7fffff, 32'h40000000, 32'h0);
    repeat (6) step(0);
    check("flag_acc1", flag_acc[9:5], 5'h05);
    clr_next = 4'b0010;
    step(0);
    clr_next = '0;
    step(0);
    check("flag_acc1_clr", flag_acc[9:5], 5'h00);
`endif
    for (int n = 0; n < 3000; n++) begin
      int pct;
      if (n % 100 == 0) begin
        rdy_pct = $urandom_range(100);
        pct = $urandom_range(100);
      end
      if ($urandom_range(499) == 0) do_reset();
      step(pct);
    end
    rdy_pct = 100;
    for (int i = 0; i < 100 && q.size() > 0; i++) step(0);
    check("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
